fft_butterfly_scheduler: RTL

In-place radix-2 DIT FFT controller. It is the initiator side of the butterfly handshake (new_input_flag / ready_flag).
- Buffers N complex samples in an internal register-file RAM.
- Runs log2(N) stages of N/2 butterflies each through one external butterfly unit, issuing operand pairs and twiddle indices and writing results back.
- Streams the spectrum out with a valid/ready handshake.
- Sits between the sample source and the output sink, and drives the intermediate butterfly instance.

---
 rtl/fft_butterfly_scheduler_pkg.sv | 22 ++
 rtl/fft_addr_gen.sv | 28 ++
 rtl/fft_butterfly_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fft_butterfly_scheduler_pkg.sv
// rtl/fft_butterfly_scheduler_pkg.sv - shared sizes, FSM encoding and bit-reversal helper
package fft_butterfly_scheduler_pkg;
  localparam int N       = 16;
  localparam int LOG2N   = 4;
  localparam int DW      = 16;
  localparam int TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_UNLOAD
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_addr_gen.sv
// rtl/fft_addr_gen.sv - radix-2 in-place operand addresses and twiddle index for (stage, butterfly)
module fft_addr_gen
  import fft_butterfly_scheduler_pkg::*;
#(
  parameter int AW = LOG2N
) (
  input  logic [2:0]    s,
  input  logic [AW-2:0] k,
  output logic [AW-1:0] a,
  output logic [AW-1:0] b,
  output logic [3:0]    tw
);
  logic [AW-1:0] half;
  logic [AW-1:0] j;
  logic [AW-1:0] grp;
  logic [AW-1:0] base;

  // Groups of 2*half entries; j walks inside a group, grp selects the group.
  always_comb begin
    half = AW'(1) << s;
    j    = {1'b0, k} & (half - AW'(1));
    grp  = {1'b0, k} >> s;
    base = (grp << (s + 3'd1)) | j;
    a    = base;
    b    = base | half;
    tw   = 4'(j << (3'(AW - 1) - s));
  end
endmodule

// File: rtl/fft_butterfly_scheduler.sv
// rtl/fft_butterfly_scheduler.sv - in-place radix-2 DIT FFT controller driving one external butterfly
module fft_butterfly_scheduler
  import fft_butterfly_scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic          busy,
  output logic          err,
  output logic [DW-1:0] bf_ra,
  output logic [DW-1:0] bf_ca,
  output logic [DW-1:0] bf_rb,
  output logic [DW-1:0] bf_cb,
  output logic [3:0]    bf_twiddle_num,
  output logic          bf_new_input_flag,
  input  logic [DW-1:0] bf_o_ra,
  input  logic [DW-1:0] bf_o_ca,
  input  logic [DW-1:0] bf_o_rb,
  input  logic [DW-1:0] bf_o_cb,
  input  logic          bf_ready_flag
);
  localparam int AW  = LOG2N;
  localparam int KW  = LOG2N - 1;
  localparam int TCW = $clog2(TIMEOUT);

  state_t         state;
  logic [AW-1:0]  n_cnt;
  logic [AW-1:0]  m_cnt;
  logic [AW-1:0]  m_next;
  logic [2:0]     s_cnt;
  logic [KW-1:0]  k_cnt;
  logic [TCW-1:0] w_cnt;
  logic [AW-1:0]  addr_a;
  logic [AW-1:0]  addr_b;
  logic [3:0]     tw;
  logic           load_we;
  logic           wb_we;
  logic           last_bf;

  logic [DW-1:0]  ram_re [N];
  logic [DW-1:0]  ram_im [N];

  fft_addr_gen #(.AW(AW)) u_addr_gen (
    .s  (s_cnt),
    .k  (k_cnt),
    .a  (addr_a),
    .b  (addr_b),
    .tw (tw)
  );

  assign load_we = (state == ST_LOAD) && in_valid && in_ready;
  assign wb_we   = (state == ST_WAIT) && bf_ready_flag;
  assign last_bf = (s_cnt == 3'(LOG2N - 1)) && (k_cnt == KW'(N/2 - 1));
  assign m_next  = m_cnt + AW'(1);

  // Samples land bit-reversed so the DIT passes can run in place and emit natural order.
  always_ff @(posedge clk) begin
    if (load_we) begin
      ram_re[bitrev(n_cnt)] <= in_re;
      ram_im[bitrev(n_cnt)] <= in_im;
    end
    if (wb_we) begin
      ram_re[addr_a] <= bf_o_ra;
      ram_im[addr_a] <= bf_o_ca;
      ram_re[addr_b] <= bf_o_rb;
      ram_im[addr_b] <= bf_o_cb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      n_cnt             <= '0;
      m_cnt             <= '0;
      s_cnt             <= '0;
      k_cnt             <= '0;
      w_cnt             <= '0;
      in_ready          <= 1'b0;
      out_valid         <= 1'b0;
      out_re            <= '0;
      out_im            <= '0;
      out_last          <= 1'b0;
      busy              <= 1'b0;
      err               <= 1'b0;
      bf_ra             <= '0;
      bf_ca             <= '0;
      bf_rb             <= '0;
      bf_cb             <= '0;
      bf_twiddle_num    <= '0;
      bf_new_input_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_LOAD;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          n_cnt    <= '0;
        end
        ST_LOAD: begin
          if (load_we) begin
            n_cnt <= n_cnt + AW'(1);
            if (n_cnt == AW'(N - 1)) begin
              in_ready <= 1'b0;
              s_cnt    <= '0;
              k_cnt    <= '0;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          bf_ra             <= ram_re[addr_a];
          bf_ca             <= ram_im[addr_a];
          bf_rb             <= ram_re[addr_b];
          bf_cb             <= ram_im[addr_b];
          bf_twiddle_num    <= tw;
          bf_new_input_flag <= 1'b1;
          w_cnt             <= '0;
          state             <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bf_ready_flag) begin
            bf_new_input_flag <= 1'b0;
            state             <= ST_GAP;
          end else if (w_cnt == TCW'(TIMEOUT - 1)) begin
            err               <= 1'b1;
            bf_new_input_flag <= 1'b0;
            busy              <= 1'b0;
            state             <= ST_IDLE;
          end else begin
            w_cnt <= w_cnt + TCW'(1);
          end
        end
        ST_GAP: begin
          if (last_bf) begin
            out_valid <= 1'b1;
            out_re    <= ram_re[0];
            out_im    <= ram_im[0];
            out_last  <= 1'b0;
            m_cnt     <= '0;
            s_cnt     <= '0;
            k_cnt     <= '0;
            state     <= ST_UNLOAD;
          end else begin
            if (k_cnt == KW'(N/2 - 1)) begin
              k_cnt <= '0;
              s_cnt <= s_cnt + 3'd1;
            end else begin
              k_cnt <= k_cnt + KW'(1);
            end
            state <= ST_ISSUE;
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              m_cnt    <= m_next;
              out_re   <= ram_re[m_next];
              out_im   <= ram_im[m_next];
              out_last <= (m_next == AW'(N - 1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
